// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - op encodings driven by the decode stage onto mdu.op
//   - FSM state type
//   - default busy-period lengths and counter width
//   - abs32 helper for the signed divider
package mdu_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W           = 16;

  // Magnitude of a two's-complement word; 0x80000000 maps to itself, which
  // is the correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/mdu.sv
// mdu: MIPS multiply/divide unit holding the architectural HI/LO pair.
//   MULT/MULTU/DIV/DIVU compute at issue into pending registers, then hold
//   busy for MULT_CYCLES/DIV_CYCLES cycles and commit on the last edge.
//   MTHI/MTLO write hi/lo in one cycle without busy.
// Ports:
//   clk    in   1   clock, rising edge
//   reset  in   1   asynchronous active-low reset
//   start  in   1   issue op this cycle (ignored while busy)
//   op     in   3   operation code (mdu_pkg OP_*)
//   a      in  32   rs operand
//   b      in  32   rt operand
//   busy   out  1   multi-cycle operation in progress
//   hi     out 32   HI register
//   lo     out 32   LO register
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_e             state_r, state_nxt_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
  logic               busy_r, busy_nxt_s;
  logic [31:0]        hi_r, hi_nxt_s;
  logic [31:0]        lo_r, lo_nxt_s;
  logic [31:0]        pend_hi_r, pend_hi_nxt_s;
  logic [31:0]        pend_lo_r, pend_lo_nxt_s;
  logic               pend_wr_r, pend_wr_nxt_s;

  logic [63:0]        smul_s, umul_s;
  logic               dzero_s;
  logic [31:0]        udiv_b_s, uq_s, ur_s;
  logic [31:0]        mag_a_s, mag_b_s, mq_s, mr_s, sq_s, sr_s;

  // Products: sign-extending both operands to 64 bits makes the low 64 bits
  // of the unsigned product equal to the signed product.
  assign smul_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign umul_s = {32'd0, a} * {32'd0, b};

  // Division: a zero divisor is replaced by 1 so the dividers never see x/0;
  // the result is discarded at commit anyway.
  assign dzero_s  = (b == 32'd0);
  assign udiv_b_s = dzero_s ? 32'd1 : b;
  assign uq_s     = a / udiv_b_s;
  assign ur_s     = a % udiv_b_s;

  // Signed division on magnitudes; quotient sign is the XOR of operand signs,
  // remainder follows the dividend. 0x80000000 / -1 yields 0x80000000, rem 0.
  assign mag_a_s = abs32(a);
  assign mag_b_s = dzero_s ? 32'd1 : abs32(b);
  assign mq_s    = mag_a_s / mag_b_s;
  assign mr_s    = mag_a_s % mag_b_s;
  assign sq_s    = (a[31] ^ b[31]) ? (32'd0 - mq_s) : mq_s;
  assign sr_s    = a[31] ? (32'd0 - mr_s) : mr_s;

  // Next-state and next-value logic for the FSM, counter and HI/LO.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    busy_nxt_s    = busy_r;
    hi_nxt_s      = hi_r;
    lo_nxt_s      = lo_r;
    pend_hi_nxt_s = pend_hi_r;
    pend_lo_nxt_s = pend_lo_r;
    pend_wr_nxt_s = pend_wr_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT: begin
              pend_hi_nxt_s = smul_s[63:32];
              pend_lo_nxt_s = smul_s[31:0];
              pend_wr_nxt_s = 1'b1;
              cnt_nxt_s     = CNT_W'(MULT_CYCLES);
              busy_nxt_s    = 1'b1;
              state_nxt_s   = ST_BUSY;
            end
            OP_MULTU: begin
              pend_hi_nxt_s = umul_s[63:32];
              pend_lo_nxt_s = umul_s[31:0];
              pend_wr_nxt_s = 1'b1;
              cnt_nxt_s     = CNT_W'(MULT_CYCLES);
              busy_nxt_s    = 1'b1;
              state_nxt_s   = ST_BUSY;
            end
            OP_DIV: begin
              pend_hi_nxt_s = sr_s;
              pend_lo_nxt_s = sq_s;
              pend_wr_nxt_s = ~dzero_s;
              cnt_nxt_s     = CNT_W'(DIV_CYCLES);
              busy_nxt_s    = 1'b1;
              state_nxt_s   = ST_BUSY;
            end
            OP_DIVU: begin
              pend_hi_nxt_s = ur_s;
              pend_lo_nxt_s = uq_s;
              pend_wr_nxt_s = ~dzero_s;
              cnt_nxt_s     = CNT_W'(DIV_CYCLES);
              busy_nxt_s    = 1'b1;
              state_nxt_s   = ST_BUSY;
            end
            OP_MTHI: hi_nxt_s = a;
            OP_MTLO: lo_nxt_s = a;
            OP_NOP:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // Counter holds the number of busy edges still to come; the edge
        // that sees 1 is the last one and commits.
        if (cnt_r == CNT_W'(1)) begin
          state_nxt_s = ST_IDLE;
          busy_nxt_s  = 1'b0;
          cnt_nxt_s   = '0;
          if (pend_wr_r) begin
            hi_nxt_s = pend_hi_r;
            lo_nxt_s = pend_lo_r;
          end else begin
            hi_nxt_s = hi_r;
            lo_nxt_s = lo_r;
          end
        end else begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        busy_nxt_s  = 1'b0;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // State, counter, pending result and architectural HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      busy_r    <= 1'b0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
      pend_wr_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      busy_r    <= busy_nxt_s;
      hi_r      <= hi_nxt_s;
      lo_r      <= lo_nxt_s;
      pend_hi_r <= pend_hi_nxt_s;
      pend_lo_r <= pend_lo_nxt_s;
      pend_wr_r <= pend_wr_nxt_s;
    end
  end

  assign busy = busy_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed self-checking bench for mdu with an expected-result queue.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int errors;
  logic [63:0] sb_q[$];
  logic [31:0] m_hi, m_lo;

  mdu dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one start cycle; operands are scrambled afterwards to show they
  // are sampled only at the issue edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = OP_NOP; a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic run_long(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int n_exp,
                          input logic [31:0] eh, input logic [31:0] el);
    int n;
    logic [63:0] e;
    sb_q.push_back({eh, el});
    issue(o, x, y);
    chk({tag, " hold_hi"}, hi, m_hi);
    chk({tag, " hold_lo"}, lo, m_lo);
    wait_done(n);
    chk({tag, " busy_cycles"}, n, n_exp);
    e = sb_q.pop_front();
    chk({tag, " hi"}, hi, e[63:32]);
    chk({tag, " lo"}, lo, e[31:0]);
    m_hi = e[63:32];
    m_lo = e[31:0];
  endtask

  task automatic run_mt(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] eh, input logic [31:0] el);
    logic [63:0] e;
    sb_q.push_back({eh, el});
    issue(o, x, 32'd0);
    chk({tag, " busy"}, {31'd0, busy}, 32'd0);
    e = sb_q.pop_front();
    chk({tag, " hi"}, hi, e[63:32]);
    chk({tag, " lo"}, lo, e[31:0]);
    m_hi = e[63:32];
    m_lo = e[31:0];
  endtask

  initial begin
    int n, tot;
    int sx, sy;
    int unsigned ux, uy;
    longint p;
    checks = 0; errors = 0;
    m_hi = 32'd0; m_lo = 32'd0;
    reset = 1'b0; start = 1'b0; op = OP_NOP; a = 32'd0; b = 32'd0;

    // Reset state, before any clock edge
    #2;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    run_mt("mthi", OP_MTHI, 32'h12345678, 32'h12345678, 32'h0);

    run_long("mult", OP_MULT, 32'hFFFFFFFF, 32'd2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_long("multu", OP_MULTU, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE);
    run_long("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_long("divu", OP_DIVU, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    run_long("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000);

    run_mt("mthi2", OP_MTHI, 32'hAAAA0000, 32'hAAAA0000, m_lo);
    run_mt("mtlo2", OP_MTLO, 32'h00005555, 32'hAAAA0000, 32'h00005555);
    run_long("divu_z", OP_DIVU, 32'd7, 32'd0, 10, 32'hAAAA0000, 32'h00005555);
    run_long("div_z", OP_DIV, 32'hFFFFFFF9, 32'd0, 10, 32'hAAAA0000, 32'h00005555);

    // NOP and undefined op: no effect, no busy
    run_mt("nop", OP_NOP, 32'h11111111, m_hi, m_lo);
    run_mt("undef", 3'd7, 32'h22222222, m_hi, m_lo);

    // Random operands against a bench-side arithmetic model
    for (int i = 0; i < 3; i++) begin
      sx = $urandom; sy = $urandom;
      p = longint'(sx) * longint'(sy);
      run_long("mult_rnd", OP_MULT, sx, sy, 5, p[63:32], p[31:0]);
      ux = $urandom; uy = $urandom_range(1, 70000);
      run_long("divu_rnd", OP_DIVU, ux, uy, 10, ux % uy, ux / uy);
      sy = $urandom;
      if (sy == 0 || sy == -1) sy = -3;
      run_long("div_rnd", OP_DIV, sx, sy, 10, sx % sy, sx / sy);
    end

    // start during BUSY (MTLO then DIV) must be ignored
    sb_q.push_back({32'd0, 32'd12});
    issue(OP_MULT, 32'd3, 32'd4);
    start = 1'b1; op = OP_MTLO; a = 32'hDEADBEEF; b = 32'd0;
    @(posedge clk); #1;
    chk("ign busy1", {31'd0, busy}, 32'd1);
    chk("ign lo1", lo, m_lo);
    op = OP_DIV; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; op = OP_NOP;
    wait_done(n);
    tot = 2 + n;
    chk("ign busy_cycles", tot, 5);
    begin
      logic [63:0] e;
      e = sb_q.pop_front();
      chk("ign hi", hi, e[63:32]);
      chk("ign lo", lo, e[31:0]);
      m_hi = e[63:32]; m_lo = e[31:0];
    end
    repeat (3) @(posedge clk);
    #1;
    chk("ign no_div", {31'd0, busy}, 32'd0);
    chk("ign lo_after", lo, 32'd12);

    // Asynchronous reset in mid-DIV discards the pending result
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst hi", hi, 32'd0);
    chk("midrst lo", lo, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("postrst busy", {31'd0, busy}, 32'd0);
    chk("postrst hi", hi, 32'd0);
    chk("postrst lo", lo, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
